// File: rtl/frequency_measure_pkg.sv
// Shared types, constants and the divider-code helper
// for the slow-clock period meter.
package freq_meas_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEASURE
    } state_t;

    localparam int REF_PERIOD   = 1024;
    localparam int CODE_STEP_SH = 6;
    localparam int CODE_ROUND   = 32;
    localparam int CODE_MAX     = 15;

    // Invert T = 1024 - 64*P with rounding; long periods map to 0,
    // short ones saturate at the largest code.
    function automatic logic [3:0] code_of(input logic [31:0] t);
        logic signed [11:0] d;
        logic signed [11:0] q;
        logic [3:0]         res;
        d = '0;
        q = '0;
        res = 4'd0;
        if (t < 32'(REF_PERIOD)) begin
            d = $signed(12'(REF_PERIOD + CODE_ROUND))
              - $signed({2'b00, t[9:0]});
            q = d >>> CODE_STEP_SH;
            if (q > $signed(12'(CODE_MAX)))
                res = 4'(CODE_MAX);
            else
                res = q[3:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/frequency_measure_if.sv
// Control and result bundle of the period meter.
// master drives enable/sig_in, slave reports results.
interface frequency_measure_if #(
    parameter int CNT_W = 11
);
    logic             enable;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [3:0]       code;
    logic             valid;
    logic             locked;
    logic             overflow;

    modport master (
        output enable,
        output sig_in,
        input  period,
        input  code,
        input  valid,
        input  locked,
        input  overflow
    );

    modport slave (
        input  enable,
        input  sig_in,
        output period,
        output code,
        output valid,
        output locked,
        output overflow
    );
endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input
// followed by a one-cycle rising-edge pulse.
module sync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic rise
);
    logic sync1;
    logic sync2;
    logic sync3;

    // Resynchronize d and keep one extra delayed copy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= d;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;
endmodule

// File: rtl/frequency_measure.sv
// Measures rising-edge to rising-edge period of a slow
// square wave and recovers the selector divider code.
module frequency_measure
    import freq_meas_pkg::*;
#(
    parameter int CNT_W    = 11,
    parameter int LOCK_TOL = 1
) (
    input logic                 clock,
    input logic                 reset,
    frequency_measure_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   TOL     = (CNT_W+1)'(LOCK_TOL);

    state_t           state;
    state_t           state_nxt;
    logic             rise;
    logic             en_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_nxt;
    logic [3:0]       code_q;
    logic [3:0]       code_nxt;
    logic             valid_q;
    logic             valid_nxt;
    logic             locked_q;
    logic             locked_nxt;
    logic             ovf_q;
    logic             ovf_nxt;
    logic             first_q;
    logic             first_nxt;
    logic [CNT_W:0]   delta;
    logic             in_tol;

    sync_edge_detect u_sync (
        .clock (clock),
        .reset (reset),
        .d     (bus.sig_in),
        .rise  (rise)
    );

    // Distance between the running count and the last capture.
    always_comb begin
        delta = '0;
        if (cnt >= period_q)
            delta = {1'b0, cnt} - {1'b0, period_q};
        else
            delta = {1'b0, period_q} - {1'b0, cnt};
        in_tol = (delta <= TOL);
    end

    // Next-state, counter and result update logic.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        period_nxt = period_q;
        code_nxt   = code_q;
        valid_nxt  = 1'b0;
        locked_nxt = locked_q;
        ovf_nxt    = ovf_q;
        first_nxt  = first_q;
        if (bus.enable && !en_d)
            ovf_nxt = 1'b0;
        if (!bus.enable) begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            locked_nxt = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    if (rise) begin
                        state_nxt = MEASURE;
                        cnt_nxt   = CNT_ONE;
                        first_nxt = 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_nxt = cnt;
                        code_nxt   = code_of(32'(cnt));
                        valid_nxt  = 1'b1;
                        cnt_nxt    = CNT_ONE;
                        locked_nxt = !first_q && in_tol;
                        first_nxt  = 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        ovf_nxt    = 1'b1;
                        locked_nxt = 1'b0;
                        state_nxt  = WAIT_EDGE;
                        cnt_nxt    = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            en_d     <= 1'b0;
            cnt      <= '0;
            period_q <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            ovf_q    <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            en_d     <= bus.enable;
            cnt      <= cnt_nxt;
            period_q <= period_nxt;
            code_q   <= code_nxt;
            valid_q  <= valid_nxt;
            locked_q <= locked_nxt;
            ovf_q    <= ovf_nxt;
            first_q  <= first_nxt;
        end
    end

    assign bus.period   = period_q;
    assign bus.code     = code_q;
    assign bus.valid    = valid_q;
    assign bus.locked   = locked_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_frequency_measure.sv
// Directed bench for frequency_measure: periods, codes,
// lock, overflow and reset behaviour.
module tb_frequency_measure;
    import freq_meas_pkg::*;

    typedef struct {
        int p;
        int c;
        bit l;
        int cyc;
    } cap_t;

    logic clock;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    cap_t q[$];

    frequency_measure_if #(.CNT_W(11)) bus ();

    frequency_measure #(
        .CNT_W    (11),
        .LOCK_TOL (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.valid)
            q.push_back('{int'(bus.period), int'(bus.code),
                          bus.locked, cyc});
    end

    task automatic drive(input logic v, input int n);
        bus.sig_in = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic gap();
        bus.enable = 1'b0;
        drive(1'b0, 4);
        q.delete();
        bus.enable = 1'b1;
        drive(1'b0, 2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.sig_in = 1'b0;
        #1;
        n_tests++;
        if ({bus.period, bus.code, bus.valid, bus.locked,
             bus.overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got p=%0d c=%0d v=%b l=%b o=%b want 0",
                     bus.period, bus.code, bus.valid, bus.locked,
                     bus.overflow);
        end
        n_tests++;
        if (dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d",
                     dut.state, IDLE);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 2);
    endtask

    task automatic test_period_1024();
        gap();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 512);
            drive(1'b0, 512);
        end
        drive(1'b1, 8);
        n_tests++;
        if (q.size() !== 3) begin
            n_fail++;
            $display("FAIL p1024_count: got %0d want 3", q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (q[i].p !== 1024 || q[i].c !== 0
                    || q[i].l !== (i > 0)) begin
                    n_fail++;
                    $display("FAIL p1024_cap%0d: got p=%0d c=%0d l=%b want p=1024 c=0 l=%b",
                             i, q[i].p, q[i].c, q[i].l, i > 0);
                end
            end
            for (int i = 1; i < 3; i++) begin
                n_tests++;
                if (q[i].cyc - q[i-1].cyc !== 1024) begin
                    n_fail++;
                    $display("FAIL p1024_gap%0d: got %0d want 1024",
                             i, q[i].cyc - q[i-1].cyc);
                end
            end
        end
    endtask

    task automatic test_code_points();
        int hp[4] = '{256, 32, 600, 16};
        int ec[4] = '{8, 15, 0, 15};
        for (int k = 0; k < 4; k++) begin
            gap();
            for (int i = 0; i < 2; i++) begin
                drive(1'b1, hp[k]);
                drive(1'b0, hp[k]);
            end
            drive(1'b1, 8);
            n_tests++;
            if (q.size() !== 2) begin
                n_fail++;
                $display("FAIL code_hp%0d_count: got %0d want 2",
                         hp[k], q.size());
            end else if (q[1].p !== 2 * hp[k]
                         || q[1].c !== ec[k]) begin
                n_fail++;
                $display("FAIL code_hp%0d: got p=%0d c=%0d want p=%0d c=%0d",
                         hp[k], q[1].p, q[1].c, 2 * hp[k], ec[k]);
            end
        end
    endtask

    task automatic test_lock();
        int per[6] = '{511, 512, 513, 512, 511, 520};
        bit el[6]  = '{0, 1, 1, 1, 1, 0};
        gap();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 256);
            drive(1'b0, per[i] - 256);
        end
        drive(1'b1, 8);
        n_tests++;
        if (q.size() !== 6) begin
            n_fail++;
            $display("FAIL lock_count: got %0d want 6", q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (q[i].p !== per[i] || q[i].l !== el[i]) begin
                    n_fail++;
                    $display("FAIL lock_cap%0d: got p=%0d l=%b want p=%0d l=%b",
                             i, q[i].p, q[i].l, per[i], el[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        gap();
        drive(1'b1, 5);
        drive(1'b0, 2035);
        n_tests++;
        if (bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_early: got %b want 0", bus.overflow);
        end
        drive(1'b0, 20);
        n_tests++;
        if (bus.overflow !== 1'b1 || bus.locked !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_set: got o=%b l=%b want o=1 l=0",
                     bus.overflow, bus.locked);
        end
        n_tests++;
        if (dut.state !== WAIT_EDGE) begin
            n_fail++;
            $display("FAIL ovf_state: got %0d want %0d",
                     dut.state, WAIT_EDGE);
        end
        n_tests++;
        if (q.size() !== 0) begin
            n_fail++;
            $display("FAIL ovf_valid: got %0d captures want 0",
                     q.size());
        end
        bus.enable = 1'b0;
        drive(1'b0, 2);
        n_tests++;
        if (bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_hold: got %b want 1", bus.overflow);
        end
        bus.enable = 1'b1;
        drive(1'b0, 2);
        n_tests++;
        if (bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b want 0", bus.overflow);
        end
    endtask

    task automatic test_reset_mid();
        gap();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64);
            drive(1'b0, 448);
        end
        drive(1'b1, 64);
        drive(1'b0, 36);
        n_tests++;
        if (bus.period !== 11'd512 || bus.code !== 4'd8) begin
            n_fail++;
            $display("FAIL rst_pre: got p=%0d c=%0d want p=512 c=8",
                     bus.period, bus.code);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.period, bus.code, bus.valid, bus.locked,
             bus.overflow} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outs: got p=%0d c=%0d v=%b l=%b o=%b want 0",
                     bus.period, bus.code, bus.valid, bus.locked,
                     bus.overflow);
        end
        @(negedge clock);
        drive(1'b0, 3);
        reset = 1'b0;
        drive(1'b0, 400);
        q.delete();
        drive(1'b1, 64);
        drive(1'b0, 448);
        n_tests++;
        if (q.size() !== 0) begin
            n_fail++;
            $display("FAIL rst_arm_valid: got %0d captures want 0",
                     q.size());
        end
        drive(1'b1, 8);
        n_tests++;
        if (q.size() !== 1) begin
            n_fail++;
            $display("FAIL rst_after_count: got %0d want 1", q.size());
        end else if (q[0].p !== 512 || q[0].c !== 8
                     || q[0].l !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after_cap: got p=%0d c=%0d l=%b want p=512 c=8 l=0",
                     q[0].p, q[0].c, q[0].l);
        end
    endtask

    initial begin
        test_reset();
        test_period_1024();
        test_code_points();
        test_lock();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
